// File: rtl/gates_checker.sv
// On-board self-checking driver for a two-input gates block: walks {a,b} through 00..11,
// waits SETTLE cycles per vector, then compares the six gate outputs with the truth table.
module gates_checker #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       nd,
  input  logic       r,
  input  logic       nnd,
  input  logic       nr,
  input  logic       xr,
  input  logic       nxr,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_vec,
  output logic [5:0] err_bits,
  output logic [2:0] fail_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_vec_q, err_vec_d;
  logic [5:0] err_bits_q, err_bits_d;
  logic [2:0] fail_cnt_q, fail_cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [5:0] observed;
  logic [5:0] expected;
  logic [5:0] mismatch;

  // Ordering {nd,r,nnd,nr,xr,nxr} matches the err_bits layout, bit 5 down to 0.
  assign observed = {nd, r, nnd, nr, xr, nxr};
  assign expected = {vec_q[1] & vec_q[0],
                     vec_q[1] | vec_q[0],
                     ~(vec_q[1] & vec_q[0]),
                     ~(vec_q[1] | vec_q[0]),
                     vec_q[1] ^ vec_q[0],
                     ~(vec_q[1] ^ vec_q[0])};

  // Case-inequality so that X/Z on a returned output counts as a failure in simulation.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_cmp
      assign mismatch[gi] = (observed[gi] !== expected[gi]);
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_vec_d  = err_vec_q;
    err_bits_d = err_bits_q;
    fail_cnt_d = fail_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          vec_d      = 2'd0;
          cnt_d      = 4'd0;
          err_vec_d  = 4'd0;
          err_bits_d = 6'd0;
          fail_cnt_d = 3'd0;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        err_bits_d = err_bits_q | mismatch;
        if (|mismatch) begin
          err_vec_d[vec_q] = 1'b1;
          fail_cnt_d       = fail_cnt_q + 3'd1;
        end
        // The last vector stays on {a,b} through DONE.
        if (vec_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= 2'd0;
      cnt_q      <= 4'd0;
      err_vec_q  <= 4'd0;
      err_bits_q <= 6'd0;
      fail_cnt_q <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      err_vec_q  <= err_vec_d;
      err_bits_q <= err_bits_d;
      fail_cnt_q <= fail_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign a        = vec_q[1];
  assign b        = vec_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = done_q && (err_vec_q == 4'd0);
  assign err_vec  = err_vec_q;
  assign err_bits = err_bits_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_gates_checker.sv
// Directed bench for gates_checker: two instances (SETTLE=2 and SETTLE=1) each driving a
// behavioural gates stand-in with selectable faults.
module tb_gates_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1;
  int   fault0, fault1;
  int   checks = 0;
  int   errors = 0;

  logic       a0, b0, busy0, done0, pass0;
  logic [3:0] ev0;
  logic [5:0] eb0, g0;
  logic [2:0] fc0;
  logic       a1, b1, busy1, done1, pass1;
  logic [3:0] ev1;
  logic [5:0] eb1, g1;
  logic [2:0] fc1;

  // Stand-in gates block: 0 = correct, 1 = nd stuck-0, 2 = xr inverted.
  function automatic logic [5:0] gates_model(input logic a, input logic b, input int fault);
    logic [5:0] o;
    o = {a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    if (fault == 1) o[5] = 1'b0;
    if (fault == 2) o[1] = ~o[1];
    return o;
  endfunction

  always_comb g0 = gates_model(a0, b0, fault0);
  always_comb g1 = gates_model(a1, b1, fault1);

  gates_checker #(.SETTLE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .nd(g0[5]), .r(g0[4]), .nnd(g0[3]), .nr(g0[2]), .xr(g0[1]), .nxr(g0[0]),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_vec(ev0), .err_bits(eb0), .fail_cnt(fc0)
  );

  gates_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .nd(g1[5]), .r(g1[4]), .nnd(g1[3]), .nr(g1[2]), .xr(g1[1]), .nxr(g1[0]),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_vec(ev1), .err_bits(eb1), .fail_cnt(fc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // One SETTLE=2 run on instance 0; start is pulsed for E0 only.
  task automatic run0(input string tag, input int f, input logic [3:0] exp_ev,
                      input logic [5:0] exp_eb, input logic [2:0] exp_fc, input logic exp_pass);
    fault0 = f;
    @(negedge clk);
    start0 = 1'b1;
    edge1();
    start0 = 1'b0;
    check({tag, "_e0_ab"}, {30'd0, a0, b0}, 32'd0);
    check({tag, "_e0_busy_done"}, {30'd0, busy0, done0}, 32'h2);
    check({tag, "_e0_cleared"}, {19'd0, ev0, eb0, fc0}, 32'd0);
    for (int e = 1; e <= 12; e++) begin
      edge1();
      if (e == 3)  check({tag, "_e3_ab"}, {30'd0, a0, b0}, 32'd1);
      if (e == 6)  check({tag, "_e6_ab"}, {30'd0, a0, b0}, 32'd2);
      if (e == 9)  check({tag, "_e9_ab"}, {30'd0, a0, b0}, 32'd3);
      if (e == 11) check({tag, "_e11_busy_done"}, {30'd0, busy0, done0}, 32'h2);
      if (busy0 && done0) check({tag, "_busy_and_done"}, 32'd1, 32'd0);
    end
    check({tag, "_e12_busy_done"}, {30'd0, busy0, done0}, 32'h1);
    check({tag, "_e12_pass"}, {31'd0, pass0}, {31'd0, exp_pass});
    check({tag, "_e12_err_vec"}, {28'd0, ev0}, {28'd0, exp_ev});
    check({tag, "_e12_err_bits"}, {26'd0, eb0}, {26'd0, exp_eb});
    check({tag, "_e12_fail_cnt"}, {29'd0, fc0}, {29'd0, exp_fc});
    check({tag, "_e12_ab_hold"}, {30'd0, a0, b0}, 32'd3);
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    fault0 = 0;
    fault1 = 0;
    #1;
    check("reset_outs0", {15'd0, a0, b0, busy0, done0, pass0, ev0, eb0, fc0}, 32'd0);
    check("reset_outs1", {15'd0, a1, b1, busy1, done1, pass1, ev1, eb1, fc1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    edge1();
    check("idle_after_release", {15'd0, a0, b0, busy0, done0, pass0, ev0, eb0, fc0}, 32'd0);

    run0("good", 0, 4'b0000, 6'b000000, 3'd0, 1'b1);
    edge1();
    check("done_held", {30'd0, busy0, done0}, 32'h1);
    run0("nd_stuck0", 1, 4'b1000, 6'b100000, 3'd1, 1'b0);
    run0("xr_inv", 2, 4'b1111, 6'b000010, 3'd4, 1'b0);

    // start held high: DONE is re-accepted on the next edge and results clear.
    fault0 = 2;
    @(negedge clk);
    start0 = 1'b1;
    for (int e = 0; e <= 26; e++) begin
      edge1();
      if (e == 5)  check("hold_e5_busy_done", {30'd0, busy0, done0}, 32'h2);
      if (e == 12) check("hold_e12_done_ev", {27'd0, done0, ev0}, 32'h1F);
      if (e == 13) check("hold_e13_restart", {24'd0, busy0, done0, a0, b0, ev0}, 32'h80);
      if (e == 25) begin
        check("hold_e25_done_ev", {27'd0, done0, ev0}, 32'h1F);
        check("hold_e25_fail_cnt", {29'd0, fc0}, 32'd4);
        start0 = 1'b0;
      end
      if (e == 26) check("hold_e26_done_held", {30'd0, busy0, done0}, 32'h1);
      if (busy0 && done0) check("hold_busy_and_done", 32'd1, 32'd0);
    end

    // Asynchronous reset mid-run, with a partial failure already recorded.
    @(negedge clk);
    start0 = 1'b1;
    edge1();
    start0 = 1'b0;
    repeat (5) edge1();
    check("mid_run_state", {26'd0, busy0, b0, ev0}, 32'h31);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", {15'd0, a0, b0, busy0, done0, pass0, ev0, eb0, fc0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run0("after_reset", 0, 4'b0000, 6'b000000, 3'd0, 1'b1);

    // SETTLE=1 instance: good run then nd stuck-0 run.
    for (int run = 0; run < 2; run++) begin
      fault1 = run;
      @(negedge clk);
      start1 = 1'b1;
      edge1();
      start1 = 1'b0;
      check("s1_e0_cleared", {24'd0, busy1, done1, ev1, a1, b1}, 32'h80);
      for (int e = 1; e <= 8; e++) begin
        edge1();
        if (e == 2) check("s1_e2_ab", {30'd0, a1, b1}, 32'd1);
        if (e == 7) check("s1_e7_done", {31'd0, done1}, 32'd0);
      end
      check("s1_e8_done_pass", {30'd0, done1, pass1}, (run == 0) ? 32'h3 : 32'h2);
      check("s1_e8_err_vec", {28'd0, ev1}, (run == 0) ? 32'h0 : 32'h8);
      check("s1_e8_err_bits_cnt", {23'd0, eb1, fc1}, (run == 0) ? 32'h0 : 32'h101);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
